// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG control sequencer.
//   state_e    : sequencer state encoding (4 bits)
//   addr_sel_e : memory address mux select (PC, PC+1, PC+2, operand A, operand B)
//   SEL_PC_*   : PC source select (PC+3 or branch target C)
package subneg_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StRdA    = 4'd1,
    StRdB    = 4'd2,
    StRdC    = 4'd3,
    StRdOp1  = 4'd4,
    StRdOp2  = 4'd5,
    StWrite  = 4'd6,
    StBranch = 4'd7,
    StPause  = 4'd8,
    StHalt   = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    AddrPc  = 3'd0,
    AddrPc1 = 3'd1,
    AddrPc2 = 3'd2,
    AddrOpa = 3'd3,
    AddrOpb = 3'd4
  } addr_sel_e;

  localparam logic SEL_PC_INC = 1'b0;
  localparam logic SEL_PC_C   = 1'b1;

endpackage

// File: rtl/subneg_sequencer_wait_ctr.sv
// Memory-latency wait counter.
//   clk_i  : clock
//   rst_i  : synchronous reset, active high
//   clr_i  : return the count to 0 on the next edge
//   done_o : count has reached MEM_LAT (constantly 1 when MEM_LAT = 0)
module subneg_wait_ctr #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int unsigned W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(MEM_LAT));

endmodule

// File: rtl/subneg_sequencer.sv
// Control sequencer for the SUBNEG core: mem[B] <- mem[B] - mem[A]; if negative PC <- C,
// else PC <- PC+3. Drives datapath strobes, tolerates read latency, supports start/stop,
// single-step, self-loop halt and a saturating retired-instruction counter.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i, stop_i        : run control (stop is latched until the next IDLE entry)
//   step_mode_i, step_i    : pause after every instruction / run one more from PAUSE
//   neg_i, self_loop_i     : datapath flags, sampled in BRANCH
//   addr_sel_o, mem_rd_o, mem_wr_o : memory address select, read and write enables
//   ld_{a,b,c,op1,op2}_o   : operand register load strobes
//   write_pc_o, sel_pc_o   : PC update enable and source
//   busy_o, halted_o       : status
//   instr_count_o          : retired instructions, saturating
module subneg_sequencer
  import subneg_pkg::*;
#(
  parameter int unsigned MEM_LAT           = 1,
  parameter int unsigned CNT_W             = 32,
  parameter bit          HALT_ON_SELF_LOOP = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic             neg_i,
  input  logic             self_loop_i,
  output logic [2:0]       addr_sel_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             ld_a_o,
  output logic             ld_b_o,
  output logic             ld_c_o,
  output logic             ld_op1_o,
  output logic             ld_op2_o,
  output logic             write_pc_o,
  output logic             sel_pc_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  state_e           state_d, state_q;
  logic             stop_d, stop_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             rd_state, wait_done, halt_now, stop_req;

  assign rd_state = state_q inside {StRdA, StRdB, StRdC, StRdOp1, StRdOp2};
  assign halt_now = HALT_ON_SELF_LOOP && neg_i && self_loop_i;
  assign stop_req = stop_i || stop_q;

  // Counter restarts at every read-state entry: cleared outside reads and on the last wait cycle.
  subneg_wait_ctr #(
    .MEM_LAT(MEM_LAT)
  ) u_wait_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!rd_state || wait_done),
    .done_o(wait_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!stop_req && start_i) state_d = StRdA;
      StRdA:    if (wait_done) state_d = StRdB;
      StRdB:    if (wait_done) state_d = StRdC;
      StRdC:    if (wait_done) state_d = StRdOp1;
      StRdOp1:  if (wait_done) state_d = StRdOp2;
      StRdOp2:  if (wait_done) state_d = StWrite;
      StWrite:  state_d = StBranch;
      StBranch: begin
        if (halt_now)         state_d = StHalt;
        else if (stop_q)      state_d = StIdle;
        else if (step_mode_i) state_d = StPause;
        else                  state_d = StRdA;
      end
      StPause: begin
        if (stop_req)    state_d = StIdle;
        else if (step_i) state_d = StRdA;
      end
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Stop request survives until the sequencer actually reaches IDLE.
  assign stop_d = (state_d == StIdle) ? 1'b0 : stop_req;
  assign cnt_d  = (state_q == StBranch && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are masked during reset so an aborted instruction never writes memory or PC.
  always_comb begin
    addr_sel_o = AddrPc;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    ld_a_o     = 1'b0;
    ld_b_o     = 1'b0;
    ld_c_o     = 1'b0;
    ld_op1_o   = 1'b0;
    ld_op2_o   = 1'b0;
    write_pc_o = 1'b0;
    sel_pc_o   = SEL_PC_INC;
    busy_o     = 1'b0;
    halted_o   = 1'b0;
    if (!rst_i) begin
      busy_o   = !(state_q inside {StIdle, StPause, StHalt});
      halted_o = (state_q == StHalt);
      unique case (state_q)
        StRdA:   begin mem_rd_o = 1'b1; addr_sel_o = AddrPc;  ld_a_o   = wait_done; end
        StRdB:   begin mem_rd_o = 1'b1; addr_sel_o = AddrPc1; ld_b_o   = wait_done; end
        StRdC:   begin mem_rd_o = 1'b1; addr_sel_o = AddrPc2; ld_c_o   = wait_done; end
        StRdOp1: begin mem_rd_o = 1'b1; addr_sel_o = AddrOpa; ld_op1_o = wait_done; end
        StRdOp2: begin mem_rd_o = 1'b1; addr_sel_o = AddrOpb; ld_op2_o = wait_done; end
        StWrite: begin mem_wr_o = 1'b1; addr_sel_o = AddrOpb; end
        StBranch: begin
          if (!halt_now) begin
            write_pc_o = 1'b1;
            sel_pc_o   = neg_i ? SEL_PC_C : SEL_PC_INC;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_subneg_sequencer.sv
// Bench for subneg_sequencer. Two instances (MEM_LAT=0/CNT_W=2 and MEM_LAT=3/CNT_W=32) share
// the inputs; the one under test is selected by cur. Expected strobe events are queued by the
// stimulus and consumed by a negedge monitor.
module tb_subneg_sequencer;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, start_i, stop_i, step_mode_i, step_i, neg_i, self_loop_i;

  logic [2:0]  d0_addr, d1_addr;
  logic        d0_rd, d0_wr, d0_la, d0_lb, d0_lc, d0_l1, d0_l2, d0_wpc, d0_sel, d0_busy, d0_halt;
  logic        d1_rd, d1_wr, d1_la, d1_lb, d1_lc, d1_l1, d1_l2, d1_wpc, d1_sel, d1_busy, d1_halt;
  logic [1:0]  d0_cnt;
  logic [31:0] d1_cnt;

  subneg_sequencer #(.MEM_LAT(0), .CNT_W(2), .HALT_ON_SELF_LOOP(1'b1)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .step_mode_i(step_mode_i), .step_i(step_i), .neg_i(neg_i), .self_loop_i(self_loop_i),
    .addr_sel_o(d0_addr), .mem_rd_o(d0_rd), .mem_wr_o(d0_wr), .ld_a_o(d0_la), .ld_b_o(d0_lb),
    .ld_c_o(d0_lc), .ld_op1_o(d0_l1), .ld_op2_o(d0_l2), .write_pc_o(d0_wpc), .sel_pc_o(d0_sel),
    .busy_o(d0_busy), .halted_o(d0_halt), .instr_count_o(d0_cnt)
  );

  subneg_sequencer #(.MEM_LAT(3), .CNT_W(32), .HALT_ON_SELF_LOOP(1'b1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .step_mode_i(step_mode_i), .step_i(step_i), .neg_i(neg_i), .self_loop_i(self_loop_i),
    .addr_sel_o(d1_addr), .mem_rd_o(d1_rd), .mem_wr_o(d1_wr), .ld_a_o(d1_la), .ld_b_o(d1_lb),
    .ld_c_o(d1_lc), .ld_op1_o(d1_l1), .ld_op2_o(d1_l2), .write_pc_o(d1_wpc), .sel_pc_o(d1_sel),
    .busy_o(d1_busy), .halted_o(d1_halt), .instr_count_o(d1_cnt)
  );

  int          cur = 0;
  int          lat = 0;
  int unsigned cmax = 3;
  int unsigned n_ret = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          rd_cycles = 0;

  logic [2:0]  o_addr;
  logic [6:0]  o_strb;  // {ld_a, ld_b, ld_c, ld_op1, ld_op2, mem_wr, write_pc}
  logic        o_rd, o_sel, o_busy, o_halt;
  logic [31:0] o_cnt;

  always_comb begin
    if (cur == 0) begin
      o_addr = d0_addr; o_rd = d0_rd; o_sel = d0_sel; o_busy = d0_busy; o_halt = d0_halt;
      o_strb = {d0_la, d0_lb, d0_lc, d0_l1, d0_l2, d0_wr, d0_wpc};
      o_cnt  = {30'd0, d0_cnt};
    end else begin
      o_addr = d1_addr; o_rd = d1_rd; o_sel = d1_sel; o_busy = d1_busy; o_halt = d1_halt;
      o_strb = {d1_la, d1_lb, d1_lc, d1_l1, d1_l2, d1_wr, d1_wpc};
      o_cnt  = d1_cnt;
    end
  end

  typedef struct {
    logic [6:0]  strb;
    int          cyc;
    logic [2:0]  asel;
    logic        chk_asel;
    logic        rd;
    logic        sel;
    logic [31:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, dut%0d)", name, got, exp, cyc, cur);
    end
  endtask

  function automatic logic [31:0] sat(int unsigned n);
    return (n > cmax) ? cmax : n;
  endfunction

  // Monitor: every strobe the DUT raises must match the next expected event.
  always @(negedge clk_i) begin : mon
    ev_t e;
    if (o_rd) rd_cycles++;
    if (o_strb != 7'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %b, expected none (cycle %0d, dut%0d)",
                 o_strb, cyc, cur);
      end else begin
        e = exp_q.pop_front();
        chk("strobe", {25'd0, o_strb}, {25'd0, e.strb});
        chk("strobe_cycle", cyc, e.cyc);
        if (e.chk_asel) chk("addr_sel", {29'd0, o_addr}, {29'd0, e.asel});
        chk("mem_rd", {31'd0, o_rd}, {31'd0, e.rd});
        chk("sel_pc", {31'd0, o_sel}, {31'd0, e.sel});
        chk("instr_count", o_cnt, e.cnt);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_to(int t);
    if (t > cyc) tick(t - cyc);
  endtask

  // Expected strobes of one instruction whose RD_A starts in cycle s.
  task automatic push_instr(int s, logic ng, logic do_wr, logic do_pc);
    ev_t e;
    logic [6:0] base;
    base = 7'b1000000;
    e.cnt = sat(n_ret);
    for (int k = 0; k < 5; k++) begin
      e.strb = base >> k; e.cyc = s + (k + 1) * (lat + 1) - 1; e.asel = 3'(k);
      e.chk_asel = 1'b1; e.rd = 1'b1; e.sel = 1'b0;
      exp_q.push_back(e);
    end
    if (do_wr) begin
      e.strb = 7'b0000010; e.cyc = s + 5 * (lat + 1); e.asel = 3'd4;
      e.chk_asel = 1'b1; e.rd = 1'b0; e.sel = 1'b0;
      exp_q.push_back(e);
    end
    if (do_pc) begin
      e.strb = 7'b0000001; e.cyc = s + 5 * (lat + 1) + 1; e.asel = 3'd0;
      e.chk_asel = 1'b0; e.rd = 1'b0; e.sel = ng;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_quiet(string name, logic exp_halt);
    chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({name, "_halted"}, {31'd0, o_halt}, {31'd0, exp_halt});
    chk({name, "_count"}, o_cnt, sat(n_ret));
  endtask

  task automatic do_reset();
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; step_mode_i = 1'b0; step_i = 1'b0;
    neg_i = 1'b0; self_loop_i = 1'b0;
    tick(2);
    chk("rst_strobes", {25'd0, o_strb}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst_i = 1'b0;
    n_ret = 0;
    tick(1);
    chk("reset_addr_sel", {29'd0, o_addr}, 32'd0);
    chk("reset_mem_rd", {31'd0, o_rd}, 32'd0);
    chk_quiet("reset", 1'b0);
  endtask

  // n back-to-back instructions, stop pulsed during RD_OP1 of the last one.
  task automatic run_seq(int n);
    int s;
    logic ng;
    rd_cycles = 0;
    start_i = 1'b1; s = cyc + 1; tick(1); start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      ng = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      neg_i = ng;
      self_loop_i = ng ? 1'b0 : 1'($urandom_range(0, 1));
      push_instr(s, ng, 1'b1, 1'b1);
      n_ret++;
      if (i == n - 1) begin
        wait_to(s + 3 * (lat + 1) + $urandom_range(0, lat));
        stop_i = 1'b1; tick(1); stop_i = 1'b0;
      end
      s = s + 5 * (lat + 1) + 2;
      wait_to(s);
    end
    neg_i = 1'b0; self_loop_i = 1'b0;
    tick(2);
    chk_quiet("after_stop", 1'b0);
    chk("mem_rd_cycles", rd_cycles, n * 5 * (lat + 1));
  endtask

  task automatic one_instr_from(int s);
    logic ng;
    ng = 1'($urandom_range(0, 1));
    neg_i = ng; self_loop_i = 1'b0;
    push_instr(s, ng, 1'b1, 1'b1);
    n_ret++;
    wait_to(s + 5 * (lat + 1) + 2);
  endtask

  task automatic phase();
    int s;
    do_reset();
    run_seq(5);

    // start together with stop in IDLE: nothing runs
    start_i = 1'b1; stop_i = 1'b1; tick(1); start_i = 1'b0; stop_i = 1'b0;
    tick(4);
    chk_quiet("start_stop_idle", 1'b0);

    // single-step
    step_mode_i = 1'b1;
    start_i = 1'b1; s = cyc + 1; tick(1); start_i = 1'b0;
    one_instr_from(s);
    tick(3);
    chk_quiet("pause1", 1'b0);
    start_i = 1'b1; tick(1); start_i = 1'b0; tick(2);   // start ignored in PAUSE
    step_i = 1'b1; s = cyc + 1; tick(1); step_i = 1'b0;
    one_instr_from(s);
    tick(2);
    chk_quiet("pause2", 1'b0);
    step_i = 1'b1; stop_i = 1'b1; tick(1); step_i = 1'b0; stop_i = 1'b0;
    step_i = 1'b1; tick(1); step_i = 1'b0; tick(4);      // step ignored in IDLE
    chk_quiet("step_stop_idle", 1'b0);
    step_mode_i = 1'b0;

    // self-loop halt
    start_i = 1'b1; s = cyc + 1; tick(1); start_i = 1'b0;
    neg_i = 1'b1; self_loop_i = 1'b1;
    push_instr(s, 1'b1, 1'b1, 1'b0);
    wait_to(s + 5 * (lat + 1) + 1);
    chk("halt_branch_write_pc", {31'd0, o_strb[0]}, 32'd0);
    chk("halt_branch_busy", {31'd0, o_busy}, 32'd1);
    n_ret++;
    tick(1);
    chk_quiet("halted", 1'b1);
    start_i = 1'b1; step_i = 1'b1; tick(1); start_i = 1'b0; step_i = 1'b0;
    stop_i = 1'b1; tick(1); stop_i = 1'b0; tick(3);
    chk_quiet("halt_held", 1'b1);
    do_reset();

    // reset landing in the WRITE cycle
    start_i = 1'b1; s = cyc + 1; tick(1); start_i = 1'b0;
    push_instr(s, 1'b0, 1'b0, 1'b0);
    wait_to(s + 5 * (lat + 1));
    rst_i = 1'b1; #1;
    chk("rst_write_mem_wr", {25'd0, o_strb}, 32'd0);
    tick(1); rst_i = 1'b0;
    n_ret = 0;
    chk("post_rst_strobes", {25'd0, o_strb}, 32'd0);
    chk("post_rst_mem_rd", {31'd0, o_rd}, 32'd0);
    chk_quiet("post_rst", 1'b0);
    tick(2);
    run_seq(2);
    chk("queue_end", exp_q.size(), 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; step_mode_i = 1'b0; step_i = 1'b0;
    neg_i = 1'b0; self_loop_i = 1'b0;
    cur = 0; lat = 0; cmax = 3;
    phase();
    cur = 1; lat = 3; cmax = 32'hFFFF_FFFF;
    phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
